bin2bcd_display_feeder: RTL

BIN2BCD_DISPLAY_FEEDER -- requirements
Module: bin2bcd_display_feeder

---
 rtl/bin2bcd_display_feeder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bin2bcd_display_feeder.sv
// Binary-to-BCD converter that feeds an 8-digit seven-segment display.
// The converter is a serial double-dabble engine: one shift per clock.
// After the last shift it registers the packed BCD value, the per-digit
// enables (leading-zero blanking) and the decimal point mask.
// Operands above 99_999_999 saturate the display to all nines.
module bin2bcd_display_feeder #(
    parameter int BIN_WIDTH = 27
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin_in,
    input  logic                 blank_en,
    input  logic                 point_en,
    input  logic [2:0]           point_pos,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [31:0]          value,
    output logic [7:0]           enable,
    output logic [7:0]           point
);

    localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_WIDTH - 1);
    localparam logic [31:0] MAX_DISPLAY = 32'd99_999_999;
    localparam logic [31:0] ALL_NINES   = 32'h9999_9999;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;

    // Operand and display options latched at start; no reset needed
    // because they are only consumed while a conversion is running.
    logic [BIN_WIDTH-1:0] operand;
    logic [31:0]          acc;
    logic                 blank_lat;
    logic                 point_en_lat;
    logic [2:0]           point_pos_lat;
    logic                 ovf_lat;

    logic [31:0]          acc_adj;
    logic [31:0]          acc_next;
    logic [31:0]          final_value;
    logic [7:0]           final_enable;
    logic [7:0]           final_point;

    // Add 3 to every BCD nibble that is 5 or more (the "dabble" step).
    function automatic logic [31:0] add3_all(input logic [31:0] bcd);
        logic [31:0] res;
        res = bcd;
        for (int i = 0; i < 8; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    // Clamp the displayed value to all nines when the operand is too large.
    function automatic logic [31:0] saturate(input logic [31:0] bcd,
                                             input logic        ovf);
        return ovf ? ALL_NINES : bcd;
    endfunction

    // Digit i is lit unless blanking is on and it is a leading zero that
    // lies above the decimal point.
    function automatic logic [7:0] digit_enable(input logic [31:0] bcd,
                                                input logic        blank,
                                                input logic        pt_en,
                                                input logic [2:0]  pt_pos);
        logic [7:0] en;
        for (int i = 0; i < 8; i++) begin
            en[i] = !blank || (i == 0) || ((bcd >> (4 * i)) != 32'd0) ||
                    (pt_en && (i <= int'(pt_pos)));
        end
        return en;
    endfunction

    // One-hot decimal point mask, or none when the point is disabled.
    function automatic logic [7:0] point_mask(input logic       pt_en,
                                              input logic [2:0] pt_pos);
        return pt_en ? (8'h01 << pt_pos) : 8'h00;
    endfunction

    // Next accumulator: dabble, then shift in the operand MSB; the bit
    // shifted out of the top is only non-zero on overflow, which is
    // flagged separately.
    always_comb begin
        acc_adj      = add3_all(acc);
        acc_next     = 32'({acc_adj, operand[BIN_WIDTH-1]});
        final_value  = saturate(acc_next, ovf_lat);
        final_enable = digit_enable(final_value, blank_lat, point_en_lat, point_pos_lat);
        final_point  = point_mask(point_en_lat, point_pos_lat);
    end

    // Datapath: capture operands on an accepted start, shift while converting.
    always_ff @(posedge clock) begin
        if (state == IDLE && start) begin
            operand       <= bin_in;
            acc           <= '0;
            blank_lat     <= blank_en;
            point_en_lat  <= point_en;
            point_pos_lat <= point_pos;
            ovf_lat       <= (32'(bin_in) > MAX_DISPLAY);
        end else if (state == CONVERT) begin
            acc     <= acc_next;
            operand <= operand << 1;
        end
    end

    // Control FSM with registered status and display outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            value    <= 32'h0;
            enable   <= 8'h01;
            point    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= CONVERT;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                CONVERT: begin
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        overflow <= ovf_lat;
                        value    <= final_value;
                        enable   <= final_enable;
                        point    <= final_point;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
